// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multicycle MIPS controller.
//   state_t  - controller FSM states (4 bits, also exported on the debug port)
//   alu_op_t - ALU operation request (3 bits)
//   OP_*     - opcodes decoded in DECODE
//   *_SEL    - datapath mux select encodings
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] PC_SEL_ALU    = 2'd0;
  localparam logic [1:0] PC_SEL_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  localparam logic       SRCA_SEL_PC = 1'b0;
  localparam logic       SRCA_SEL_A  = 1'b1;

  localparam logic [1:0] SRCB_SEL_B      = 2'd0;
  localparam logic [1:0] SRCB_SEL_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_SEL_IMM    = 2'd2;
  localparam logic [1:0] SRCB_SEL_IMM_SH = 2'd3;

  localparam logic IORD_SEL_PC     = 1'b0;
  localparam logic IORD_SEL_ALUOUT = 1'b1;
  localparam logic DST_SEL_RT      = 1'b0;
  localparam logic DST_SEL_RD      = 1'b1;
  localparam logic WB_SEL_ALUOUT   = 1'b0;
  localparam logic WB_SEL_MDR      = 1'b1;

  // ALU operation for the I-type arithmetic/logic group.
  function automatic alu_op_t imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Logical immediates are zero-extended, everything else sign-extended.
  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath/memory signal bundle.
//   master - controller side: consumes opcode/funct/zero/mem_ready,
//            drives selects, enables, memory request and status.
//   slave  - datapath side, mirror image.
// Memory handshake: mem_req is held high for the whole request; the request
// completes in the cycle where mem_req and mem_ready are both high.
// mem_ready while mem_req is low carries no meaning and is ignored.
interface mc_if;
  import mc_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  alu_op_t    alu_op;
  logic       ext_zero;
  logic       illegal;
  logic       mem_err;
  state_t     state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_zero, illegal,
           mem_err, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_zero, illegal,
           mem_err, state
  );

endinterface

// File: rtl/mc_mem_timer.sv
// mc_mem_timer: counts stalled memory-request cycles.
//   clk, rst  - clock, synchronous active-high reset (clears the count)
//   count_i   - request pending and not yet acknowledged this cycle
//   clear_i   - handshake completed this cycle
//   expire_o  - this stalled cycle is the MEM_TIMEOUT-th one in a row
// MEM_TIMEOUT = 0 disables expiry.
module mc_mem_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic count_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // The count holds the number of earlier stalled cycles, so the cycle that
  // sees cnt_q == MEM_TIMEOUT-1 while still stalled is the one that expires.
  assign expire_o = (MEM_TIMEOUT > 0) && count_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (count_i && !expire_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore controller for the multicycle MIPS datapath.
//   clk, rst - clock, synchronous active-high reset
//   bus      - mc_if.master: opcode/funct/zero/mem_ready in; PC/IR/regfile
//              enables, mux selects, ALU op, imm extension, memory request,
//              sticky illegal/mem_err flags and debug state out.
// Outputs decode the current state only; the FETCH IR/PC strobes follow
// mem_ready and the BRANCH PC strobe follows zero within the same cycle.
// All outputs are held at 0 while rst is high.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input logic   clk,
  input logic   rst,
  mc_if.master  bus
);

  state_t state_q;
  logic   illegal_q, mem_err_q;
  logic   tmo_expire;

  mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .count_i  (bus.mem_req && !bus.mem_ready),
    .clear_i  (bus.mem_req && bus.mem_ready),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH, MEM_RD, MEM_WR: begin
          // A handshake on the limit cycle wins over the timeout.
          if (bus.mem_ready) begin
            state_q <= (state_q == FETCH)  ? DECODE :
                       (state_q == MEM_RD) ? MEM_WB : FETCH;
          end else if (tmo_expire) begin
            state_q   <= TRAP;
            mem_err_q <= 1'b1;
          end
        end
        DECODE: begin
          case (bus.opcode)
            OP_RTYPE:               state_q <= R_EXEC;
            OP_LW, OP_SW:           state_q <= MEM_ADDR;
            OP_BEQ:                 state_q <= BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: state_q <= I_EXEC;
            OP_J:                   state_q <= JUMP;
            default: begin
              state_q   <= TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEM_ADDR: state_q <= (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
        R_EXEC:   state_q <= R_WB;
        I_EXEC:   state_q <= I_WB;
        TRAP:     state_q <= TRAP;
        default:  state_q <= FETCH;  // MEM_WB, R_WB, BRANCH, I_WB, JUMP
      endcase
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = IORD_SEL_PC;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_SEL_ALU;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = DST_SEL_RT;
    bus.mem_to_reg = WB_SEL_ALUOUT;
    bus.alu_src_a  = SRCA_SEL_PC;
    bus.alu_src_b  = SRCB_SEL_B;
    bus.alu_op     = ALU_ADD;
    bus.ext_zero   = 1'b0;
    bus.illegal    = 1'b0;
    bus.mem_err    = 1'b0;
    bus.state      = FETCH;
    if (!rst) begin
      bus.state   = state_q;
      bus.illegal = illegal_q;
      bus.mem_err = mem_err_q;
      case (state_q)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = SRCB_SEL_FOUR;
          bus.ir_we     = bus.mem_ready;
          bus.pc_we     = bus.mem_ready;
        end
        DECODE:   bus.alu_src_b = SRCB_SEL_IMM_SH;  // branch target into ALUOut
        MEM_ADDR: begin
          bus.alu_src_a = SRCA_SEL_A;
          bus.alu_src_b = SRCB_SEL_IMM;
        end
        MEM_RD: begin
          bus.mem_req = 1'b1;
          bus.iord    = IORD_SEL_ALUOUT;
        end
        MEM_WB: begin
          bus.reg_we     = 1'b1;
          bus.mem_to_reg = WB_SEL_MDR;
        end
        MEM_WR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.iord    = IORD_SEL_ALUOUT;
        end
        R_EXEC: begin
          bus.alu_src_a = SRCA_SEL_A;
          bus.alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          bus.reg_we  = 1'b1;
          bus.reg_dst = DST_SEL_RD;
        end
        BRANCH: begin
          bus.alu_src_a = SRCA_SEL_A;
          bus.alu_op    = ALU_SUB;
          bus.pc_src    = PC_SEL_ALUOUT;
          bus.pc_we     = bus.zero;
        end
        I_EXEC: begin
          bus.alu_src_a = SRCA_SEL_A;
          bus.alu_src_b = SRCB_SEL_IMM;
          bus.alu_op    = imm_alu_op(bus.opcode);
          bus.ext_zero  = imm_zero_ext(bus.opcode);
        end
        I_WB: begin
          bus.reg_we   = 1'b1;
          // IR is stable, so the extension mode matches I_EXEC.
          bus.ext_zero = imm_zero_ext(bus.opcode);
        end
        JUMP: begin
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_SEL_JUMP;
        end
        default: ;  // TRAP: status flags only
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench for mc_control. dut uses MEM_TIMEOUT=0,
// dut_tmo uses MEM_TIMEOUT=4. Each cycle the expected output vector is
// queued, then popped and compared at the falling edge.
module tb_mc_control;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_zero;
    logic       illegal;
    logic       mem_err;
  } obs_t;
  localparam int OW = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  mc_if bus1 ();
  mc_if bus2 ();

  mc_control #(.MEM_TIMEOUT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mc_control #(.MEM_TIMEOUT(4)) dut_tmo (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic obs_t obs1();
    return obs_t'({bus1.state, bus1.mem_req, bus1.mem_we, bus1.iord, bus1.ir_we,
                   bus1.pc_we, bus1.pc_src, bus1.reg_we, bus1.reg_dst,
                   bus1.mem_to_reg, bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op,
                   bus1.ext_zero, bus1.illegal, bus1.mem_err});
  endfunction

  function automatic obs_t obs2();
    return obs_t'({bus2.state, bus2.mem_req, bus2.mem_we, bus2.iord, bus2.ir_we,
                   bus2.pc_we, bus2.pc_src, bus2.reg_we, bus2.reg_dst,
                   bus2.mem_to_reg, bus2.alu_src_a, bus2.alu_src_b, bus2.alu_op,
                   bus2.ext_zero, bus2.illegal, bus2.mem_err});
  endfunction

  // ---------------- expected vectors, one per state ----------------
  function automatic obs_t e_fetch(input logic rdy);
    obs_t e = '0;
    e.st = 4'd0; e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_op = ALU_ADD;
    e.ir_we = rdy; e.pc_we = rdy;
    return e;
  endfunction

  function automatic obs_t e_decode();
    obs_t e = '0;
    e.st = 4'd1; e.alu_src_b = 2'd3; e.alu_op = ALU_ADD;
    return e;
  endfunction

  function automatic obs_t e_memaddr();
    obs_t e = '0;
    e.st = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = ALU_ADD;
    return e;
  endfunction

  function automatic obs_t e_memrd();
    obs_t e = '0;
    e.st = 4'd3; e.mem_req = 1'b1; e.iord = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_memwb();
    obs_t e = '0;
    e.st = 4'd4; e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_memwr();
    obs_t e = '0;
    e.st = 4'd5; e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_rexec();
    obs_t e = '0;
    e.st = 4'd6; e.alu_src_a = 1'b1; e.alu_op = ALU_FUNCT;
    return e;
  endfunction

  function automatic obs_t e_rwb();
    obs_t e = '0;
    e.st = 4'd7; e.reg_we = 1'b1; e.reg_dst = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_branch(input logic z);
    obs_t e = '0;
    e.st = 4'd8; e.alu_src_a = 1'b1; e.alu_op = ALU_SUB; e.pc_src = 2'd1; e.pc_we = z;
    return e;
  endfunction

  function automatic obs_t e_iexec(input alu_op_t op, input logic zx);
    obs_t e = '0;
    e.st = 4'd9; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = op; e.ext_zero = zx;
    return e;
  endfunction

  function automatic obs_t e_iwb(input logic zx);
    obs_t e = '0;
    e.st = 4'd10; e.reg_we = 1'b1; e.ext_zero = zx;
    return e;
  endfunction

  function automatic obs_t e_jump();
    obs_t e = '0;
    e.st = 4'd11; e.pc_we = 1'b1; e.pc_src = 2'd2;
    return e;
  endfunction

  function automatic obs_t e_trap(input logic ill, input logic err);
    obs_t e = '0;
    e.st = 4'd12; e.illegal = ill; e.mem_err = err;
    return e;
  endfunction

  // ---------------- driver / checker tasks ----------------
  // Called just after a rising edge with inputs already driven; checks the
  // cycle at the falling edge and returns just after the next rising edge.
  task automatic step(input string tag, input obs_t e, input bit sel);
    obs_t o, x;
    exp_q.push_back(e);
    @(negedge clk);
    o = sel ? obs2() : obs1();
    x = exp_q.pop_front();
    n_total++;
    assert (o === x) n_pass++;
    else $error("FAIL %s: observed state=%0d vec=%h expected state=%0d vec=%h",
                tag, o.st, o, x.st, x);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus1.opcode = '0; bus1.funct = 6'h20; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;
    bus2.opcode = '0; bus2.funct = 6'h20; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset: outputs forced low while rst is high.
    bus1.mem_ready = 1'b1;
    step("rst_hold", '0, 0);
    rst = 1'b0;

    // lw with immediate memory response.
    bus1.opcode = 6'h23; bus1.mem_ready = 1'b1;
    step("lw_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("lw_decode", e_decode(), 0);
    step("lw_addr", e_memaddr(), 0);
    bus1.mem_ready = 1'b1;
    step("lw_rd", e_memrd(), 0);
    bus1.mem_ready = 1'b0;
    step("lw_wb", e_memwb(), 0);

    // ori: zero-extend, OR, write rt; four cycles.
    bus1.opcode = 6'h0D; bus1.mem_ready = 1'b1;
    step("ori_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("ori_decode", e_decode(), 0);
    step("ori_exec", e_iexec(ALU_OR, 1'b1), 0);
    step("ori_wb", e_iwb(1'b1), 0);

    // andi and addi.
    bus1.opcode = 6'h0C; bus1.mem_ready = 1'b1;
    step("andi_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("andi_decode", e_decode(), 0);
    step("andi_exec", e_iexec(ALU_AND, 1'b1), 0);
    step("andi_wb", e_iwb(1'b1), 0);
    bus1.opcode = 6'h08; bus1.mem_ready = 1'b1;
    step("addi_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("addi_decode", e_decode(), 0);
    step("addi_exec", e_iexec(ALU_ADD, 1'b0), 0);
    step("addi_wb", e_iwb(1'b0), 0);

    // beq taken then not taken.
    for (int i = 0; i < 2; i++) begin
      bus1.opcode = 6'h04; bus1.mem_ready = 1'b1; bus1.zero = 1'b0;
      step("beq_fetch", e_fetch(1'b1), 0);
      bus1.mem_ready = 1'b0;
      step("beq_decode", e_decode(), 0);
      bus1.zero = (i == 0);
      step(i == 0 ? "beq_taken" : "beq_not_taken", e_branch(i == 0), 0);
    end
    bus1.zero = 1'b0;

    // R-type.
    bus1.opcode = 6'h00; bus1.mem_ready = 1'b1;
    step("r_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("r_decode", e_decode(), 0);
    step("r_exec", e_rexec(), 0);
    step("r_wb", e_rwb(), 0);

    // sw with a slow memory.
    bus1.opcode = 6'h2B; bus1.mem_ready = 1'b1;
    step("sw_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("sw_decode", e_decode(), 0);
    step("sw_addr", e_memaddr(), 0);
    for (int i = 0; i < 2; i++) step("sw_wait", e_memwr(), 0);
    bus1.mem_ready = 1'b1;
    step("sw_done", e_memwr(), 0);

    // FETCH stalled 5 cycles, strobe on the 6th; then jump with a stray
    // mem_ready that must be ignored.
    bus1.opcode = 6'h02; bus1.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("stall_fetch", e_fetch(1'b0), 0);
    bus1.mem_ready = 1'b1;
    step("stall_release", e_fetch(1'b1), 0);
    step("j_decode", e_decode(), 0);
    step("j_jump", e_jump(), 0);
    bus1.mem_ready = 1'b0;

    // Unknown opcode traps and stays there until reset.
    bus1.opcode = 6'h3F; bus1.mem_ready = 1'b1;
    step("ill_fetch", e_fetch(1'b1), 0);
    step("ill_decode", e_decode(), 0);
    for (int i = 0; i < 3; i++) begin
      bus1.mem_ready = 1'($urandom_range(0, 1));
      step("ill_trap", e_trap(1'b1, 1'b0), 0);
    end
    rst = 1'b1;
    step("ill_rst", '0, 0);
    rst = 1'b0;

    // Reset in R_EXEC: no write strobe, back to FETCH.
    bus1.opcode = 6'h00; bus1.mem_ready = 1'b1;
    step("rrst_fetch", e_fetch(1'b1), 0);
    bus1.mem_ready = 1'b0;
    step("rrst_decode", e_decode(), 0);
    rst = 1'b1;
    step("rrst_abort", '0, 0);
    rst = 1'b0;
    step("rrst_refetch", e_fetch(1'b0), 0);

    // Timeout instance: handshake on the limit cycle wins.
    rst2 = 1'b0;
    bus2.opcode = 6'h2B; bus2.mem_ready = 1'b1;
    step("tw_fetch", e_fetch(1'b1), 1);
    bus2.mem_ready = 1'b0;
    step("tw_decode", e_decode(), 1);
    step("tw_addr", e_memaddr(), 1);
    for (int i = 0; i < 3; i++) step("tw_wait", e_memwr(), 1);
    bus2.mem_ready = 1'b1;
    step("tw_limit_ready", e_memwr(), 1);
    bus2.mem_ready = 1'b0;
    step("tw_no_err", e_fetch(1'b0), 1);

    // Memory never answers the store: error after four stalled cycles.
    bus2.mem_ready = 1'b1;
    step("to_fetch", e_fetch(1'b1), 1);
    bus2.mem_ready = 1'b0;
    step("to_decode", e_decode(), 1);
    step("to_addr", e_memaddr(), 1);
    for (int i = 0; i < 4; i++) step("to_wait", e_memwr(), 1);
    step("to_trap", e_trap(1'b0, 1'b1), 1);
    step("to_trap_hold", e_trap(1'b0, 1'b1), 1);
    rst2 = 1'b1;
    step("to_rst", '0, 1);
    rst2 = 1'b0;
    step("to_after_rst", e_fetch(1'b0), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Moore FSM that sequences the multicycle MIPS datapath: PC, IR, register file, ALU, memory port and immediate extender.
- Decodes the latched opcode, drives every datapath select and write enable, and owns the memory request/ready handshake.
- Selects sign or zero extension for the 16-bit immediate: zero for andi/ori, sign for everything else.
- Sits between the instruction register and the datapath mux/enable inputs.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for mem_ready before raising mem_err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]; pass-through only, decoded by the ALU
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register write
- pc_we  out  1  PC write, including the taken-branch case
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- reg_we  out  1  register file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = ext_imm, 3 = ext_imm<<2
- alu_op  out  3  alu_op_t
- ext_zero  out  1  1 = zero-extend imm, 0 = sign-extend
- illegal  out  1  sticky; unknown opcode trapped
- mem_err  out  1  sticky; memory timeout
- state  out  4  current state, debug only

Behaviour:
- All outputs are pure functions of state (Moore). Unlisted outputs are 0 in every state.
- Reset:
  - rst high at a clk edge sets state = FETCH and clears illegal, mem_err and the timeout counter.
  - While rst is high, all outputs are forced to 0.
  - rst mid-instruction abandons it; no write enable pulses in that cycle.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - While mem_ready=0: hold.
  - On mem_ready=1, in the same cycle: ir_we=1, pc_we=1, pc_src=0; next state DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD, ext_zero=0 (precomputes the branch target).
  - Next state by opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x08, 0x0C, 0x0D -> I_EXEC
    - 0x02 -> JUMP
    - any other -> TRAP
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=ADD, ext_zero=0.
  - Next state: MEM_RD if opcode is 0x23, else MEM_WR.
- MEM_RD:
  - Outputs: mem_req=1, iord=1.
  - Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1; next FETCH.
- MEM_WR:
  - Outputs: mem_req=1, mem_we=1, iord=1.
  - Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=FUNCT; next R_WB.
- R_WB: reg_we=1, reg_dst=1, mem_to_reg=0; next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_we = zero (same cycle).
  - Next FETCH.
- I_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=2.
  - alu_op = ADD for 0x08, AND for 0x0C, OR for 0x0D.
  - ext_zero = 1 for 0x0C and 0x0D.
  - Next I_WB.
- I_WB:
  - Outputs: reg_we=1, reg_dst=0, mem_to_reg=0.
  - ext_zero is held at its I_EXEC value.
  - Next FETCH.
- JUMP: pc_we=1, pc_src=2; next FETCH.
- TRAP: illegal=1, no enables asserted; stays until rst.
- Timeout (MEM_TIMEOUT>0):
  - Counter increments each cycle mem_req=1 and mem_ready=0, and clears on any handshake.
  - When the count reaches MEM_TIMEOUT: set mem_err and go to TRAP.
  - mem_ready arriving in the same cycle the limit is reached wins: the handshake completes and no error is raised.
- mem_ready outside the request states is ignored.
- opcode may change after DECODE. Correctness relies on the IR holding its value, since ir_we is asserted only in FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - state_t enum, 4 bits: FETCH=0, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, I_EXEC, I_WB, JUMP, TRAP.
  - alu_op_t, 3 bits: ADD=0, SUB=1, FUNCT=2, AND=3, OR=4.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J.
  - Mux select constants.
- One sub-module, mc_mem_timer: the timeout counter with its start/clear/expire interface.

Test Plan:
- lw, opcode 0x23, mem_ready=1 immediately -> state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; reg_we=1 and mem_to_reg=1 only in MEM_WB; ext_zero=0 throughout.
- ori, opcode 0x0D -> ext_zero=1 and alu_op=OR in I_EXEC; reg_we=1 and reg_dst=0 in I_WB; total 4 cycles.
- beq, opcode 0x04: zero=1 -> pc_we=1, pc_src=1 in BRANCH; repeated with zero=0 -> pc_we stays 0.
- FETCH with mem_ready low for 5 cycles -> mem_req held, ir_we=0 for 5 cycles; pulse on cycle 6 -> ir_we=pc_we=1 for one cycle only.
- MEM_TIMEOUT=4, mem_ready never asserted in MEM_WR -> mem_err=1 and state=TRAP after 4 cycles; rst -> FETCH with mem_err=0.
- opcode 0x3F -> TRAP with illegal=1 and no enables; rst asserted in R_EXEC -> no reg_we pulse, FETCH on the next edge.
